// File: rtl/apb_slave_regfile_pkg.sv
// Shared APB completer types: FSM state enum, bus widths, default ID.
// Also holds the address/permission error decode used at setup.
package apb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int IDX_W  = ADDR_W - 2;
   localparam int CNT_W  = 4;

   localparam logic [DATA_W-1:0] DEF_ID = 32'hA5B0_0001;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_slv_state_e;

   // Misaligned, beyond the bank, or a write to the read-only ID word.
   function automatic logic addr_err(
      input logic [ADDR_W-1:0] a,
      input logic              wr,
      input int                nregs
   );
      return (a[1:0] != 2'b00)
          || (int'(a[ADDR_W-1:2]) >= nregs)
          || (wr && (a[ADDR_W-1:2] == '0));
   endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB4 bus bundle between requester and completer.
// master drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB; slave drives PRDATA/PREADY/PSLVERR.
interface apb_slave_regfile_if;
   import apb_pkg::*;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [STRB_W-1:0] PSTRB;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE,
      output PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE,
      input  PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_slave_regfile_regbank.sv
// NUM_REGS x 32 register bank: byte-strobed write port, combinational read port.
// Ports: clk, rst_n, we/widx/wdata/wstrb (write), ridx -> rdata (read). Word 0 is ID_VALUE.
module apb_slave_regbank
   import apb_pkg::*;
#(
   parameter int                NUM_REGS = 16,
   parameter logic [DATA_W-1:0] ID_VALUE = DEF_ID
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdata
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;

   assign regs[0] = ID_VALUE;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      logic [DATA_W-1:0] q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (we && (widx == IDX_W'(g))) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wstrb[b]) begin
                  q[8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end
      end

      assign regs[g] = q;
   end

   // Out-of-range indices read as zero; the top masks them anyway.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ridx == IDX_W'(i)) begin
            rdata = regs[i];
         end
      end
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer over a byte-strobed register bank, fixed wait states, PSLVERR.
// Ports: PCLK, PRESET_n (async, active-low), apb (slave modport); outputs are registered.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int                NUM_REGS    = 16,
   parameter int                WAIT_STATES = 0,
   parameter logic [DATA_W-1:0] ID_VALUE    = DEF_ID
) (
   input  logic         PCLK,
   input  logic         PRESET_n,
   apb_slave_regfile_if.slave apb
);

   apb_slv_state_e    state_q, state_d, cur_st;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic              err_q, err_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic [DATA_W-1:0] rd_data;
   logic              setup_hit;
   logic              bank_we;

   // The setup phase is recognised while it is on the bus, so capture
   // happens at its closing edge and a zero-wait PREADY lands next cycle.
   assign setup_hit = (state_q == IDLE) && apb.PSEL && !apb.PENABLE;

   // Read index must be the one being captured when there are no waits.
   assign idx_d = setup_hit ? apb.PADDR[ADDR_W-1:2] : idx_q;

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   always_comb begin
      cur_st  = setup_hit ? SETUP : state_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      err_d   = err_q;
      unique case (cur_st)
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_STATES);
            wr_d    = apb.PWRITE;
            wdata_d = apb.PWDATA;
            strb_d  = apb.PSTRB;
            err_d   = addr_err(apb.PADDR, apb.PWRITE, NUM_REGS);
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else if (!apb.PSEL) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next-cycle outputs: PREADY goes up in the access cycle whose count is 0.
   always_comb begin
      pready_d  = (state_d == ACCESS) && (cnt_d == '0);
      pslverr_d = pready_d && err_d;
      prdata_d  = '0;
      if (pready_d && !wr_d && !err_d) begin
         prdata_d = rd_data;
      end
   end

   // Commit at the close of the PREADY cycle; an async reset wins.
   assign bank_we = (state_q == ACCESS) && pready_q && wr_q && !err_q;

   apb_slave_regbank #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (ID_VALUE)
   ) u_bank (
      .clk   (PCLK),
      .rst_n (PRESET_n),
      .we    (bank_we),
      .widx  (idx_q),
      .wdata (wdata_q),
      .wstrb (strb_q),
      .ridx  (idx_d),
      .rdata (rd_data)
   );

   assign apb.PREADY  = pready_q;
   assign apb.PSLVERR = pslverr_q;
   assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: two completers (0 and 3 wait states) on a muxed requester.
// Driver pushes expectations from a spec-level model; a negedge monitor pops and checks.
module tb_apb_slave_regfile;
   import apb_pkg::*;

   localparam int          NR  = 16;
   localparam logic [31:0] IDV = 32'hA5B0_0001;

   typedef struct {
      int          bus;
      bit          rd;
      bit          err;
      logic [31:0] data;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   int          sel;
   int          cyc;
   int          tests;
   int          fails;
   exp_t        expq[$];
   logic [31:0] mdl[2][64];

   logic        cur_pready, cur_slverr;
   logic [31:0] cur_prdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   apb_slave_regfile_if b0 ();
   apb_slave_regfile_if b3 ();

   assign b0.PSEL    = psel && (sel == 0);
   assign b3.PSEL    = psel && (sel == 1);
   assign b0.PENABLE = penable;
   assign b3.PENABLE = penable;
   assign b0.PWRITE  = pwrite;
   assign b3.PWRITE  = pwrite;
   assign b0.PADDR   = paddr;
   assign b3.PADDR   = paddr;
   assign b0.PWDATA  = pwdata;
   assign b3.PWDATA  = pwdata;
   assign b0.PSTRB   = pstrb;
   assign b3.PSTRB   = pstrb;

   assign cur_pready = (sel == 0) ? b0.PREADY  : b3.PREADY;
   assign cur_slverr = (sel == 0) ? b0.PSLVERR : b3.PSLVERR;
   assign cur_prdata = (sel == 0) ? b0.PRDATA  : b3.PRDATA;

   apb_slave_regfile #(
      .NUM_REGS    (NR),
      .WAIT_STATES (0),
      .ID_VALUE    (IDV)
   ) dut0 (
      .PCLK     (clk),
      .PRESET_n (rst_n),
      .apb      (b0)
   );

   apb_slave_regfile #(
      .NUM_REGS    (NR),
      .WAIT_STATES (3),
      .ID_VALUE    (IDV)
   ) dut3 (
      .PCLK     (clk),
      .PRESET_n (rst_n),
      .apb      (b3)
   );

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] req
   );
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, act, req);
      end
   endtask

   task automatic clr_model();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 64; i++)
            mdl[b][i] = '0;
   endtask

   // One complete transfer; returns at the negedge of its PREADY cycle.
   task automatic xfer(
      input int          b,
      input bit          wr,
      input logic [7:0]  a,
      input logic [31:0] d,
      input logic [3:0]  s
   );
      exp_t e;
      int   idx;
      int   n;
      idx    = int'(a) / 4;
      e.bus  = b;
      e.rd   = !wr;
      e.err  = (int'(a) % 4 != 0) || (idx >= NR)
            || (wr && idx == 0);
      e.lat  = (b == 0) ? 1 : 4;
      e.data = '0;
      if (!e.err)
         e.data = (idx == 0) ? IDV : mdl[b][idx];
      if (wr && !e.err)
         for (int i = 0; i < 4; i++)
            if (s[i])
               mdl[b][idx][8*i +: 8] = d[8*i +: 8];
      @(posedge clk);
      #1;
      sel     = b;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      pstrb   = s;
      e.t0    = cyc;
      expq.push_back(e);
      @(posedge clk);
      #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cur_pready && n < 40);
      if (!cur_pready) begin
         tests++;
         fails++;
         $display("FAIL xfer_timeout: addr %h no PREADY", a);
         if (expq.size() > 0)
            void'(expq.pop_front());
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         psel    = 1'b0;
         penable = 1'b0;
      end
   endtask

   // Counts PREADY on the selected bus over n negedges.
   task automatic watch(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cur_pready)
            cnt++;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (cur_pready) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL stray_pready: got 1, want 0");
            end else begin
               e = expq.pop_front();
               chk("bus", sel, e.bus);
               chk("latency", cyc - e.t0, e.lat);
               chk("pslverr", {31'd0, cur_slverr},
                   {31'd0, e.err});
               if (e.rd)
                  chk("prdata", cur_prdata, e.data);
            end
         end else begin
            chk("prdata_idle", cur_prdata, '0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench stuck");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      int r;
      logic [7:0] a;
      tests   = 0;
      fails   = 0;
      cyc     = 0;
      sel     = 0;
      rst_n   = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      clr_model();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready0", {31'd0, b0.PREADY}, 0);
      chk("rst_slverr0", {31'd0, b0.PSLVERR}, 0);
      chk("rst_prdata0", b0.PRDATA, 0);
      chk("rst_pready3", {31'd0, b3.PREADY}, 0);
      chk("rst_slverr3", {31'd0, b3.PSLVERR}, 0);
      chk("rst_prdata3", b3.PRDATA, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait write/read and partial strobes.
      xfer(0, 1, 8'h04, 32'hDEAD_BEEF, 4'hF);
      xfer(0, 0, 8'h04, 32'h0, 4'h0);
      xfer(0, 1, 8'h08, 32'h1122_3344, 4'hF);
      xfer(0, 1, 8'h08, 32'hAABB_CCDD, 4'b0101);
      xfer(0, 0, 8'h08, 32'h0, 4'hF);
      chk("strb_model", mdl[0][2], 32'h11BB_33DD);

      // Error paths.
      xfer(0, 1, 8'h00, 32'h1234_5678, 4'hF);
      xfer(0, 0, 8'h00, 32'h0, 4'h0);
      xfer(0, 0, 8'h41, 32'h0, 4'h0);
      xfer(0, 0, 8'h40, 32'h0, 4'h0);
      xfer(0, 1, 8'h40, 32'hFFFF_FFFF, 4'hF);
      xfer(0, 1, 8'h05, 32'hFFFF_FFFF, 4'hF);
      xfer(0, 0, 8'h04, 32'h0, 4'h0);

      // Three wait states.
      xfer(1, 0, 8'h00, 32'h0, 4'h0);
      xfer(1, 1, 8'h10, 32'h1234_5678, 4'hF);
      xfer(1, 0, 8'h10, 32'h0, 4'h0);

      // Abort: PSEL drops during a wait state.
      idle(1);
      @(posedge clk);
      #1;
      sel     = 1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h10;
      pwdata  = 32'hCAFE_F00D;
      pstrb   = 4'hF;
      @(posedge clk);
      #1;
      penable = 1'b1;
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      watch(8, cnt);
      chk("abort_no_pready", cnt, 0);
      xfer(1, 0, 8'h10, 32'h0, 4'h0);

      // PENABLE without a setup phase.
      idle(1);
      @(posedge clk);
      #1;
      sel     = 0;
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 8'h04;
      pwdata  = 32'h0BAD_0BAD;
      pstrb   = 4'hF;
      watch(5, cnt);
      chk("no_setup_no_pready", cnt, 0);
      idle(1);
      xfer(0, 0, 8'h04, 32'h0, 4'h0);

      // Randomised traffic on both completers, back to back.
      for (int k = 0; k < 120; k++) begin
         r = $urandom_range(0, 9);
         if (r < 7)
            a = {6'($urandom_range(0, NR - 1)), 2'b00};
         else
            a = 8'($urandom_range(0, 255));
         xfer($urandom_range(0, 1), 1'($urandom % 2),
              a, $urandom, 4'($urandom_range(0, 15)));
      end

      // Reset during the access phase of a write to 0x0C.
      xfer(0, 1, 8'h0C, 32'h55AA_55AA, 4'hF);
      xfer(0, 0, 8'h0C, 32'h0, 4'h0);
      idle(1);
      @(posedge clk);
      #1;
      sel     = 0;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h0C;
      pwdata  = 32'hFFFF_FFFF;
      pstrb   = 4'hF;
      @(posedge clk);
      #1;
      penable = 1'b1;
      chk("pre_rst_pready", {31'd0, b0.PREADY}, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pready", {31'd0, b0.PREADY}, 0);
      chk("mid_rst_slverr", {31'd0, b0.PSLVERR}, 0);
      chk("mid_rst_prdata", b0.PRDATA, 0);
      psel    = 1'b0;
      penable = 1'b0;
      clr_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(0, 0, 8'h0C, 32'h0, 4'h0);
      xfer(1, 0, 8'h10, 32'h0, 4'h0);

      idle(4);
      chk("queue_drained", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
